// File: rtl/des_pkg.sv
// Shared definitions for the DES test-vector generator: FSM states and XorShift constants.
package des_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    FILL  = 3'd2,
    OFFER = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int          DES_WORDS_PER_VEC = 4;
  localparam logic [31:0] XS_W_INIT         = 32'd88675123;

endpackage

// File: rtl/des_key_parity.sv
// Combinational 64-bit DES key odd-parity fixer: bit 8k+7 of each byte is rewritten
// so that the byte carries an odd number of ones; bits 8k..8k+6 pass through.
module des_key_parity (
  input  logic [0:63] key_i,
  output logic [0:63] key_o
);

  always_comb begin
    key_o = key_i;
    for (int k = 0; k < 8; k++) begin
      key_o[8*k+7] = ~(^key_i[8*k +: 7]);
    end
  end

endmodule

// File: rtl/des_vector_gen.sv
// Reseeds the XorShift PRNG and packs its words into DES key/plaintext vectors offered
// over valid/ready. Define DES_VECGEN_PARITY_EN to force odd parity on every key byte.
module des_vector_gen
  import des_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [0:31]      seed,
  input  logic [CNT_W-1:0] num_vec,
  output logic             busy,
  output logic             done,
  output logic             prng_rst,
  output logic [0:31]      prng_seed,
  input  logic [0:31]      rnd,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [0:63]      vec_key,
  output logic [0:63]      vec_pt,
  output logic [CNT_W-1:0] vec_idx
);

  localparam logic [1:0]       LAST_WORD = 2'(DES_WORDS_PER_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [0:31]      seed_q,  seed_d;
  logic [CNT_W-1:0] num_q,   num_d;
  logic [CNT_W-1:0] idx_q,   idx_d;
  logic [1:0]       wcnt_q,  wcnt_d;
  logic [0:63]      key_q,   key_d;
  logic [0:63]      pt_q,    pt_d;
  logic [0:63]      key_fill;
  logic [0:63]      key_fix;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      seed_q  <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      wcnt_q  <= '0;
      key_q   <= '0;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    num_d     = num_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    pt_d      = pt_q;
    key_fill  = key_q;
    busy      = 1'b0;
    done      = 1'b0;
    prng_rst  = 1'b0;
    vec_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          seed_d  = seed;
          num_d   = num_vec;
          idx_d   = '0;
          state_d = (num_vec == '0) ? DONE : SEED;
        end
      end
      SEED: begin
        busy     = 1'b1;
        prng_rst = 1'b1;
        wcnt_d   = '0;
        state_d  = FILL;
      end
      FILL: begin
        busy = 1'b1;
        case (wcnt_q)
          2'd0:    key_fill[0:31]  = rnd;
          2'd1:    key_fill[32:63] = rnd;
          2'd2:    pt_d[0:31]      = rnd;
          default: pt_d[32:63]     = rnd;
        endcase
        wcnt_d = wcnt_q + 2'd1;
        if (wcnt_q == LAST_WORD) begin
          state_d = OFFER;
        end
      end
      OFFER: begin
        busy      = 1'b1;
        vec_valid = 1'b1;
        if (vec_ready) begin
          if (idx_q == num_q - CNT_ONE) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + CNT_ONE;
            wcnt_d  = '0;
            state_d = FILL;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Parity is applied as the key is written so the held key never changes during OFFER.
`ifdef DES_VECGEN_PARITY_EN
  des_key_parity u_key_parity (
    .key_i (key_fill),
    .key_o (key_fix)
  );
`else
  assign key_fix = key_fill;
`endif

  assign key_d     = (state_q == FILL) ? key_fix : key_q;
  assign prng_seed = seed_q;
  assign vec_key   = key_q;
  assign vec_pt    = pt_q;
  assign vec_idx   = idx_q;

endmodule
